// File: rtl/execute_pkg.sv
// Shared definitions for the decode->execute pipeline register.
// Holds the control-bundle layout, the skid-buffer state encoding and a
// small helper used to turn a bundle into a bubble.
package execute_pkg;

   localparam int CTRL_W = 8;

   // Bit positions inside the packed control bundle
   localparam int CTRL_BRANCH     = 7;
   localparam int CTRL_REG_WRITE  = 6;
   localparam int CTRL_MEM_READ   = 5;
   localparam int CTRL_MEM_TO_REG = 4;
   localparam int CTRL_ALU_OP_HI  = 3;
   localparam int CTRL_ALU_OP_LO  = 2;
   localparam int CTRL_MEM_WRITE  = 1;
   localparam int CTRL_ALU_SRC    = 0;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   typedef enum logic [1:0] {
      SB_EMPTY = ST_EMPTY,
      SB_FULL  = ST_FULL,
      SB_SKID  = ST_SKID
   } sb_state_e;

   // A bubble must never write the register file or memory, so every
   // control bit is dropped when the bundle is not valid.
   function automatic logic [CTRL_W-1:0] gate_ctrl(input logic valid,
                                                   input logic [CTRL_W-1:0] ctrl);
      return valid ? ctrl : '0;
   endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry skid buffer with valid/ready on both sides and a
// synchronous flush. The main entry drives out_data; the skid entry only
// catches a bundle accepted while the consumer is stalling.
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | nothing held, out_valid=0, in_ready=1
// FULL  | main entry valid, in_ready=1
// SKID  | main + skid valid, in_ready=0
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous kill of both entries
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module pipe_skid_buffer
   import execute_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   sb_state_e        state_q, state_d;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             in_ready_q;
   logic             in_fire, out_fire;
   logic             load_main_in, load_main_skid, load_skid;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != SB_EMPTY);
   assign out_data  = main_q;

   always_comb begin
      in_fire        = in_valid & in_ready_q;
      out_fire       = out_valid & out_ready;
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         SB_EMPTY: begin
            if (in_fire) begin
               state_d      = SB_FULL;
               load_main_in = 1'b1;
            end
         end
         SB_FULL: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               state_d   = SB_SKID;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_d = SB_EMPTY;
            end
         end
         SB_SKID: begin
            if (out_fire) begin
               state_d        = SB_FULL;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = SB_EMPTY;
      endcase
   end

   // in_ready is registered from the next state so it never depends
   // combinationally on out_ready.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q    <= SB_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != SB_SKID);
         if (load_main_in)
            main_q <= in_data;
         else if (load_main_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= in_data;
      end
   end

endmodule

// File: rtl/execute_registers.sv
// Decode->execute pipeline register. Carries the decoded operand, the raw
// instruction and the control bundle through a 2-entry skid buffer so
// execute back-pressure never drops an instruction. Control bits are gated
// to zero on bubbles, and a saturating counter records stalled cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    branch-mispredict kill of all held entries
//   in_valid / in_ready      decode-side handshake
//   rm0_in, instruction_in, cu_ctrl_in   decoded bundle
//   out_valid / out_ready    execute-side handshake
//   rm0_out, instruction_out, cu_ctrl_out  head bundle
//   stall_count              cycles with out_valid=1 and out_ready=0
module execute_registers
   import execute_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] rm0_in,
   input  logic [WORD_SIZE-1:0] instruction_in,
   input  logic [CTRL_W-1:0]    cu_ctrl_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] rm0_out,
   output logic [WORD_SIZE-1:0] instruction_out,
   output logic [CTRL_W-1:0]    cu_ctrl_out,
   output logic [CNT_W-1:0]     stall_count
);

   localparam int BUNDLE_W = 2*WORD_SIZE + CTRL_W;

   logic [BUNDLE_W-1:0] bundle_in, bundle_out;
   logic [CTRL_W-1:0]   head_ctrl;
   logic [CNT_W-1:0]    stall_q;

   assign bundle_in = {rm0_in, instruction_in, cu_ctrl_in};

   pipe_skid_buffer #(
      .WIDTH (BUNDLE_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (bundle_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (bundle_out)
   );

   assign {rm0_out, instruction_out, head_ctrl} = bundle_out;
   assign cu_ctrl_out = gate_ctrl(out_valid, head_ctrl);

   // Survives flush on purpose: it is a debug statistic, not pipeline state.
   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
         stall_q <= stall_q + 1'b1;
   end

   assign stall_count = stall_q;

endmodule

// File: tb/tb_execute_registers.sv
module tb_execute_registers;

   localparam int WS = 32;
   localparam int CW = 4;

   typedef struct packed {
      logic [WS-1:0] rm0;
      logic [WS-1:0] instr;
      logic [7:0]    ctrl;
   } bundle_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WS-1:0] rm0_in = '0;
   logic [WS-1:0] instruction_in = '0;
   logic [7:0]    cu_ctrl_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [WS-1:0] rm0_out;
   logic [WS-1:0] instruction_out;
   logic [7:0]    cu_ctrl_out;
   logic [CW-1:0] stall_count;

   bundle_t       sb_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            exp_stall = 0;

   always #5 clk = ~clk;

   execute_registers #(.WORD_SIZE(WS), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .rm0_in          (rm0_in),
      .instruction_in  (instruction_in),
      .cu_ctrl_in      (cu_ctrl_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .rm0_out         (rm0_out),
      .instruction_out (instruction_out),
      .cu_ctrl_out     (cu_ctrl_out),
      .stall_count     (stall_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [WS-1:0] r);
      in_valid       = v;
      rm0_in         = r;
      instruction_in = r ^ 32'hC0DE_0000;
      cu_ctrl_in     = r[7:0] ^ 8'h5A;
   endtask

   // One clock: pop/push the scoreboard from the handshake as the model
   // sees it before the edge, then check post-edge state.
   task automatic cycle();
      bundle_t b;
      logic    exp_valid, exp_in_fire, exp_out_fire;
      exp_valid    = (sb_q.size() != 0);
      exp_out_fire = exp_valid && out_ready;
      exp_in_fire  = in_valid && (sb_q.size() < 2);
      if (!rst && exp_out_fire) begin
         b = sb_q.pop_front();
         check("rm0_out", 64'(rm0_out), 64'(b.rm0));
         check("instruction_out", 64'(instruction_out), 64'(b.instr));
         check("cu_ctrl_out", 64'(cu_ctrl_out), 64'(b.ctrl));
      end
      if (rst) begin
         sb_q.delete();
         exp_stall = 0;
      end else begin
         if (exp_valid && !out_ready && exp_stall < (1 << CW) - 1)
            exp_stall++;
         if (flush)
            sb_q.delete();
         else if (exp_in_fire) begin
            b.rm0   = rm0_in;
            b.instr = instruction_in;
            b.ctrl  = cu_ctrl_in;
            sb_q.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
      check("stall_count", 64'(stall_count), 64'(exp_stall));
      if (sb_q.size() == 0)
         check("bubble_ctrl", 64'(cu_ctrl_out), 64'h0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      cycle();
      cycle();
      check("rst_rm0", 64'(rm0_out), 64'h0);
      check("rst_instr", 64'(instruction_out), 64'h0);
      rst = 1'b0;
      cycle();

      // Streaming with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h11 + i);
         cycle();
      end
      drive(1'b0, '0);
      cycle();
      cycle();

      // Back-pressure: A, B fill both entries, C held off
      out_ready = 1'b0;
      drive(1'b1, 32'hA);
      cycle();
      drive(1'b1, 32'hB);
      cycle();
      check("bp_in_ready", 64'(in_ready), 64'h0);
      drive(1'b1, 32'hC);
      for (int i = 0; i < 3; i++) cycle();
      check("bp_head_A", 64'(rm0_out), 64'hA);
      out_ready = 1'b1;
      cycle();
      cycle();
      drive(1'b0, '0);
      cycle();
      cycle();

      // Flush while in SKID with an incoming bundle carrying all control bits
      out_ready = 1'b0;
      drive(1'b1, 32'hD);
      cycle();
      drive(1'b1, 32'hE);
      cycle();
      flush = 1'b1;
      drive(1'b1, 32'hFF00);
      cu_ctrl_in = 8'hFF;
      cycle();
      check("flush_rm0", 64'(rm0_out), 64'h0);
      check("flush_ctrl", 64'(cu_ctrl_out), 64'h0);
      flush = 1'b0;
      drive(1'b0, '0);
      out_ready = 1'b1;
      cycle();
      cycle();

      // Simultaneous in_fire and out_fire in FULL
      drive(1'b1, 32'hF0);
      cycle();
      drive(1'b1, 32'hF1);
      cycle();
      check("sim_head_new", 64'(rm0_out), 64'hF1);
      drive(1'b0, '0);
      cycle();

      // Stall counter saturation
      out_ready = 1'b0;
      drive(1'b1, 32'h5A5);
      cycle();
      drive(1'b0, '0);
      for (int i = 0; i < 20; i++) cycle();
      check("stall_sat", 64'(stall_count), 64'hF);

      // Reset while in SKID
      drive(1'b1, 32'h777);
      cycle();
      check("pre_rst_skid", 64'(in_ready), 64'h0);
      drive(1'b0, '0);
      rst = 1'b1;
      cycle();
      check("rst_skid_rm0", 64'(rm0_out), 64'h0);
      check("rst_skid_instr", 64'(instruction_out), 64'h0);
      check("rst_skid_ctrl", 64'(cu_ctrl_out), 64'h0);
      rst = 1'b0;
      out_ready = 1'b1;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
